// File: rtl/dac_sched_pkg.sv
// Shared types and helpers for the serial-DAC load scheduler: FSM states,
// word-width encoding and the round/saturate step applied when a word is loaded.
package dac_sched_pkg;

    localparam int SAMPLE_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_GAP
    } state_e;

    localparam logic [1:0] WSEL_16 = 2'd0;
    localparam logic [1:0] WSEL_18 = 2'd1;
    localparam logic [1:0] WSEL_20 = 2'd2;
    localparam logic [1:0] WSEL_24 = 2'd3;

    function automatic logic [4:0] width_bits(input logic [1:0] sel);
        case (sel)
            WSEL_16: return 5'd16;
            WSEL_18: return 5'd18;
            WSEL_20: return 5'd20;
            default: return 5'd24;
        endcase
    endfunction

    // Result stays left-justified in SAMPLE_W bits; the caller ships the top n bits.
    function automatic logic [SAMPLE_W-1:0] round_sat(input logic [SAMPLE_W-1:0] x,
                                                      input logic [4:0]          n,
                                                      input logic                rnd_en);
        logic [SAMPLE_W:0] sum;
        logic [4:0]        drop;
        if (!rnd_en || n >= 5'(SAMPLE_W)) begin
            return x;
        end
        drop = 5'(SAMPLE_W) - n;
        sum  = {x[SAMPLE_W-1], x} + ({{SAMPLE_W{1'b0}}, 1'b1} << (drop - 5'd1));
        // Sign bit 0 with bit SAMPLE_W-1 set means a positive value wrapped past full scale.
        if (sum[SAMPLE_W:SAMPLE_W-1] == 2'b01) begin
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
        return sum[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry sample queue: valid/ready push side, pop/empty side with the
// head word always visible on data_o.
module sample_fifo2 #(
    parameter int W = 24
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    input  logic         pop_i,
    output logic         empty_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push;
    logic         pop;

    assign ready_o = (count_q != 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push    = valid_i & ready_o;
    assign pop     = pop_i & ~empty_o;

    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q keeps stale entries from ever being read.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dac_load_sched.sv
// Serial-DAC load scheduler: round-robin between the L and R queues, one shared
// MSB-first shift engine, then a per-channel active-low latch-enable pulse.
module dac_load_sched
    import dac_sched_pkg::*;
#(
    parameter int FRAME = SAMPLE_W,
    parameter int LE_W  = 2,
    parameter int GAP   = 1
) (
    input  logic             bck_i,
    input  logic             rst_i,
    input  logic [1:0]       width_sel_i,
    input  logic             rnd_en_i,
    input  logic             l_valid_i,
    input  logic [FRAME-1:0] l_data_i,
    output logic             l_ready_o,
    input  logic             r_valid_i,
    input  logic [FRAME-1:0] r_data_i,
    output logic             r_ready_o,
    output logic             sdo_o,
    output logic [1:0]       le_o,
    output logic             busy_o,
    output logic             active_ch_o
);

    localparam int CNT_MAX_A = (LE_W > GAP) ? LE_W : GAP;
    localparam int CNT_MAX   = (CNT_MAX_A > FRAME) ? CNT_MAX_A : FRAME;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic             pick_q, pick_d;
    logic             active_q, active_d;
    logic             last_q, last_d;
    logic             sdo_q, sdo_d;
    logic [1:0]       le_q, le_d;
    logic [FRAME-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       nbits_q, nbits_d;

    logic             l_pop, r_pop;
    logic             l_empty, r_empty;
    logic [FRAME-1:0] l_head, r_head;
    logic [FRAME-1:0] word;
    logic             decide;

    sample_fifo2 #(.W(FRAME)) u_l_fifo (
        .clk_i   (bck_i),
        .rst_i   (rst_i),
        .valid_i (l_valid_i),
        .data_i  (l_data_i),
        .ready_o (l_ready_o),
        .pop_i   (l_pop),
        .empty_o (l_empty),
        .data_o  (l_head)
    );

    sample_fifo2 #(.W(FRAME)) u_r_fifo (
        .clk_i   (bck_i),
        .rst_i   (rst_i),
        .valid_i (r_valid_i),
        .data_i  (r_data_i),
        .ready_o (r_ready_o),
        .pop_i   (r_pop),
        .empty_o (r_empty),
        .data_o  (r_head)
    );

    // 0 = L, 1 = R; with both pending the channel not served last wins.
    function automatic logic arb_pick(input logic l_pend, input logic r_pend, input logic last);
        if (l_pend) begin
            return r_pend ? ~last : 1'b0;
        end
        return 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        pick_d   = pick_q;
        active_d = active_q;
        last_d   = last_q;
        sdo_d    = sdo_q;
        le_d     = le_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        nbits_d  = nbits_q;
        l_pop    = 1'b0;
        r_pop    = 1'b0;
        word     = '0;
        decide   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                decide = 1'b1;
            end
            ST_LOAD: begin
                l_pop    = ~pick_q;
                r_pop    = pick_q;
                active_d = pick_q;
                last_d   = pick_q;
                nbits_d  = width_bits(width_sel_i);
                word     = round_sat(pick_q ? r_head : l_head, nbits_d, rnd_en_i);
                sdo_d    = word[FRAME-1];
                sr_d     = {word[FRAME-2:0], 1'b0};
                cnt_d    = CNT_W'(1);
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(nbits_q)) begin
                    sdo_d          = 1'b0;
                    le_d[active_q] = 1'b0;
                    cnt_d          = CNT_W'(1);
                    state_d        = ST_LATCH;
                end else begin
                    sdo_d = sr_q[FRAME-1];
                    sr_d  = {sr_q[FRAME-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                if (cnt_q == CNT_W'(LE_W)) begin
                    le_d  = 2'b11;
                    cnt_d = CNT_W'(1);
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        decide = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP)) begin
                    decide = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (decide) begin
            if (!l_empty || !r_empty) begin
                state_d = ST_LOAD;
                pick_d  = arb_pick(!l_empty, !r_empty, last_q);
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge bck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pick_q   <= 1'b0;
            active_q <= 1'b0;
            last_q   <= 1'b1;
            sdo_q    <= 1'b0;
            le_q     <= 2'b11;
            sr_q     <= '0;
            cnt_q    <= '0;
            nbits_q  <= 5'd16;
        end else begin
            state_q  <= state_d;
            pick_q   <= pick_d;
            active_q <= active_d;
            last_q   <= last_d;
            sdo_q    <= sdo_d;
            le_q     <= le_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            nbits_q  <= nbits_d;
        end
    end

    assign sdo_o       = sdo_q;
    assign le_o        = le_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign active_ch_o = active_q;

endmodule

// File: doc/dac_load_sched.md
# dac_load_sched

Serial-DAC load scheduler between the I2S sample capture and the AD1860-style DAC serial pins. It buffers left/right samples in two 2-entry queues and shares one shift engine between them, arbitrating round-robin. It emits each sample MSB-first on a common data line, then pulses that channel's latch-enable low. Word width and optional rounding are run-time configurable.

## Interface
- `FRAME`, 24: captured sample width (signed, two's complement).
- `LE_W`, 2: latch-enable low pulse length in cycles (≥1).
- `GAP`, 1: idle cycles after the latch pulse before the next load (≥0).

- `bck_i`  in  1  the only clock; all state on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `width_sel_i`  in  2  DAC word width: 0=16, 1=18, 2=20, 3=24 bits.
- `rnd_en_i`  in  1  1 = round-half-up with saturation; 0 = truncate.
- `l_valid_i` / `r_valid_i`  in  1  sample offered on that channel.
- `l_data_i` / `r_data_i`  in  FRAME  sample value.
- `l_ready_o` / `r_ready_o`  out  1  queue not full; a push occurs on valid & ready.
- `sdo_o`  out  1  serial data, MSB first.
- `le_o`  out  2  latch enables; [0]=L DAC, [1]=R DAC; idle high.
- `busy_o`  out  1  FSM not in IDLE.
- `active_ch_o`  out  1  channel being serviced (0=L, 1=R).

## Operation
- Reset values: `sdo_o`=0, `le_o`=2'b11, both ready=1, `busy_o`=0, `active_ch_o`=0. Queues are emptied and `last_served`=R, so L wins first.
- Queues: 2-entry FIFO per channel. Ready depends only on full, so a full queue refuses a push even if it pops in the same cycle. No loss, no duplication, and order is preserved.
- FSM states: IDLE, LOAD, SHIFT, LATCH, GAP.
- IDLE: if any queue is non-empty, go to LOAD. If only one channel is pending, pick it. If both are pending, pick the one that is not `last_served`.
- LOAD, 1 cycle:
  - Pop the chosen queue; set `active_ch_o` and `last_served`.
  - Sample `width_sel_i` and `rnd_en_i`; N = selected width.
  - Form word W. If rounding and N<24: x + 2^(FRAME-N-1), computed in FRAME+1 bits. If the result exceeds 0x7FFFFF, clamp to 0x7FFFFF (negatives cannot overflow). Otherwise truncate. Take the top N bits of W.
  - At exit: `sdo_o`←W[N-1], shift register←remaining bits, count←1.
- SHIFT: each cycle, shift out the next bit until N bits have been held; one bit per cycle, N cycles total. At exit: `sdo_o`←0 and `le_o[active]`←0.
- LATCH: `le_o[active]` stays low for LE_W cycles. At exit it returns to 1. The other enable stays high throughout.
- GAP: GAP cycles with `sdo_o`=0. In the last GAP cycle, arbitration runs as in IDLE: go to LOAD if work is pending, else IDLE. If GAP=0, LATCH goes directly to that decision.
- Config changes after LOAD do not affect the word in flight.
- Reset mid-operation: outputs return to reset values immediately. The partial frame is abandoned and never resumed.

## Timing
- Push on edge t into an empty, idle scheduler:
  - edge t+1: IDLE→LOAD.
  - edge t+2: first data bit on `sdo_o`.
  - edges t+2+N … t+2+N+LE_W−1: `le_o` low.
- Back-to-back frame period = 1+N+LE_W+GAP cycles; 20 cycles for N=16 with the default parameters.
- With both queues pending continuously, the outputs alternate strictly L,R,L,R.
- Ready: a queue becomes full on the edge after its second unpopped push, so ready reads low in that cycle. It recovers on the edge after the pop in LOAD.

## Structure
- Package `dac_sched_pkg`: the FSM state enum, width_sel encoding constants, a `width_bits(sel)` function, and a round/saturate function.
- Sub-module `sample_fifo2`: 2-entry FIFO with a valid/ready push side and a pop/empty side, instantiated once per channel. The FSM, arbiter and shifter stay in `dac_load_sched`.

## Test plan
- Reset: hold `rst_i` → `le_o`=11, `sdo_o`=0, both ready=1, `busy_o`=0. Asserting reset mid-SHIFT returns these values immediately, and no trailing `le_o` pulse appears after release.
- Single L sample 0xA5A5A5, width 16, no rounding → `sdo_o` carries 0xA5A5 MSB-first over 16 cycles starting 2 edges after the push. Then `le_o[0]` is low for 2 cycles; `le_o[1]` stays high.
- Rounding at width 16:
  - 0x123480 → 0x1235.
  - 0x7FFF80 → 0x7FFF (saturated).
  - 0xFFFF80 → 0x0000.
  - With `rnd_en_i`=0, 0x123480 → 0x1234.
- Arbitration: push L and R in the same cycle, three samples each → service order L,R,L,R,L,R with a 20-cycle period (N=16).
- Backpressure: hold `l_valid_i` high with incrementing data for 8 cycles → `l_ready_o` drops once 2 entries are queued. Every accepted value appears exactly once, in order.
- Width change: select 24 bits, then switch to 18 during SHIFT → the current word still emits 24 bits; the next word emits 18.
